// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: FSM encoding,
// datapath width and EX/MEM memory-control bit positions.
package mem_access_ctrl_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Layout of the EX/MEM memory-control field as {write, read}
    localparam int MEMCTL_W     = 2;
    localparam int MEMCTL_READ  = 0;
    localparam int MEMCTL_WRITE = 1;

    function automatic logic is_word_aligned(input logic [1:0] byte_off);
        return byte_off == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_cnt.sv
// Wait-cycle counter for an outstanding memory access; flags the cycle on
// which the access has waited TIMEOUT cycles and must be abandoned.
module mem_access_ctrl_wait_cnt #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == TERM_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: runs one access at a time over a req/ack
// handshake, stalls the pipeline meanwhile and flags misalignment/timeouts.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [WORD_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [WORD_W-1:0] mem_rdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              timeout_o
);

    logic [1:0]          state_q,    state_d;
    logic                req_q,      req_d;
    logic                we_q,       we_d;
    logic [WORD_W-1:0]   addr_q,     addr_d;
    logic [WORD_W-1:0]   wdata_q,    wdata_d;
    logic [WORD_W-1:0]   rdata_q,    rdata_d;
    logic                misalign_q, misalign_d;
    logic                timeout_q,  timeout_d;

    logic [MEMCTL_W-1:0] memctl;
    logic                access;
    logic                aligned;
    logic                cnt_clr;
    logic                cnt_en;
    logic                cnt_term;

    assign memctl  = {memwrite_i, memread_i};
    assign access  = memctl[MEMCTL_READ] | memctl[MEMCTL_WRITE];
    assign aligned = is_word_aligned(addr_i[1:0]);

    mem_access_ctrl_wait_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .term_o  (cnt_term)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (aligned) begin
                        // A simultaneous read+write request resolves to a write
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        we_d    = memctl[MEMCTL_WRITE];
                        req_d   = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = ST_BUSY;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end

            ST_BUSY: begin
                // An ack arriving on the threshold cycle still completes the access
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                end else if (cnt_term) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    // Stall is raised in the request cycle itself so EX/MEM never advances past it
    assign stall_o = !rst_i &&
                     ((state_q == ST_BUSY) ||
                      ((state_q == ST_IDLE) && access && aligned));

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign misalign_o  = misalign_q;
    assign timeout_o   = timeout_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage controller that consumes the EX/MEM pipeline register's memory-control, ALU-result (address) and rt-data (store data) outputs.
It runs each load/store against a variable-latency data memory over a req/ack handshake and raises a stall to freeze the IF..EX/MEM pipeline while the access is outstanding.
It presents load data (registered) to the MEM/WB register.
Misaligned and timed-out accesses are detected and flagged to the hazard/exception logic.

Parameters:
TIMEOUT, 255, max cycles to wait for mem_ack_i before abort (1..2^CNT_W-1)
CNT_W, 8, width of the wait counter

Ports:
clk_i  input  1  clock, rising-edge
rst_i  input  1  reset, asynchronous, active-high
memread_i  input  1  load request (from EX/MEM mem control)
memwrite_i  input  1  store request (from EX/MEM mem control)
addr_i  input  32  byte address (EX/MEM ALU result)
wdata_i  input  32  store data (EX/MEM rt data)
mem_req_o  output  1  request to data memory
mem_we_o  output  1  1 = write, 0 = read; valid while mem_req_o
mem_addr_o  output  32  latched address; valid while mem_req_o
mem_wdata_o  output  32  latched store data; valid while mem_req_o
mem_ack_i  input  1  memory completion, one-cycle pulse
mem_rdata_i  input  32  read data, valid with mem_ack_i
rdata_o  output  32  load result to MEM/WB, registered
stall_o  output  1  freeze pipeline (combinational)
misalign_o  output  1  one-cycle pulse: addr_i[1:0] != 0 on access
timeout_o  output  1  one-cycle pulse: access aborted after TIMEOUT

Behaviour:
- Reset values (async, immediate): state IDLE, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, rdata_o 0, misalign_o 0, timeout_o 0, counter 0. stall_o 0 while rst_i high.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - access = memread_i | memwrite_i. If access and addr_i[1:0]==0: stall_o=1 combinationally in the same cycle. Next edge: latch addr/wdata; mem_we_o=memwrite_i; mem_req_o=1; counter=0; go BUSY.
  - memread_i and memwrite_i both high: treat as write.
  - Access with addr_i[1:0]!=0: no request, no stall, misalign_o=1 next cycle for one cycle, stay IDLE, rdata_o unchanged.
- BUSY:
  - stall_o=1; mem_req_o held 1 with stable addr/we/wdata until ack.
  - mem_ack_i: mem_req_o=0 next edge; if read, rdata_o<=mem_rdata_i; go DONE.
  - No ack: counter++. If counter reaches TIMEOUT-1 without ack: mem_req_o=0, timeout_o pulse, go DONE, rdata_o unchanged.
  - Ack on the same cycle as the timeout threshold: ack wins (no timeout_o).
- DONE: stall_o=0 for exactly one cycle so EX/MEM advances; unconditionally go IDLE. Inputs in DONE are ignored (still the completed instruction).
- Latency: an aligned access with ack N cycles after req rises (N>=1) holds stall_o high for N+1 cycles. rdata_o is valid from the cycle after ack and is held until the next completed load.
- mem_ack_i outside BUSY: ignored.
- Reset mid-access: mem_req_o drops asynchronously; a later ack is ignored in IDLE.
- Back-to-back accesses: IDLE, BUSY, DONE, IDLE; minimum 3 cycles per access.

Decomposition:
- Shared package (e.g. cpu_pkg): state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), WORD_W=32, EX/MEM mem-control bit positions (read/write).
- No sub-module needed. Optional: mem_wait_cnt (timeout counter with clear/enable/terminal flag).

Test Plan:
- Aligned load, addr 0x0000_0010, ack after 3 cycles with rdata 0xDEAD_BEEF -> stall_o high 4 cycles, mem_we_o=0, rdata_o=0xDEAD_BEEF from the cycle after ack, then a DONE cycle with stall_o=0.
- Aligned store, addr 0x20, wdata 0x1234_5678, ack after 1 cycle -> mem_we_o=1, mem_addr_o/mem_wdata_o stable through ack, rdata_o unchanged, stall_o high 2 cycles.
- Misaligned load, addr 0x0000_0013 -> no mem_req_o, stall_o stays 0, misalign_o single pulse.
- No ack with TIMEOUT=4 -> mem_req_o high 4 cycles, timeout_o one pulse, DONE, IDLE; stall_o released.
- Ack coincident with the timeout threshold -> data captured, timeout_o stays 0.
- rst_i asserted mid-BUSY -> mem_req_o and stall_o drop without waiting for a clock edge; a late ack after reset is ignored; next load proceeds normally.
